opponent_state_tracker: RTL and testbench
=========================================

Name: opponent_state_tracker

Overview:
- Sits directly downstream of the Ethernet receive block, on eth_refclk (50 MHz).
- Consumes its 44-bit opponent words (axiov/axiod) and drops malformed or out-of-range words.
- Holds the last good opponent kart state and publishes it to the track/racer/forward viewers only at frame start, so a frame never mixes two packets.
- Also flags link loss and turns the opponent's reset bit into a single-cycle pulse.

Parameters:
- TRACK_W, 512, exclusive upper bound for opponent_x.
- TRACK_H, 512, exclusive upper bound for opponent_y.
- DIR_MAX, 360, exclusive upper bound for opponent_dir.
- TIMEOUT_CYCLES, 5000000, clk_in cycles without a good word before the link is declared down (100 ms at 50 MHz).

Ports:
- clk_in  input  1  eth_refclk.
- rst_in  input  1  asynchronous, active-high reset.
- axiiv  input  1  word valid from receive.
- axiid  input  44  opponent word.
- frame_start_in  input  1  one-cycle pulse at the start of each displayed frame (vsync edge from vga).
- opp_x_out  output  11  published opponent x.
- opp_y_out  output  11  published opponent y.
- opp_dir_out  output  9  published opponent direction in degrees.
- opp_game_out  output  3  published game status.
- opp_reset_pulse_out  output  1  one-cycle pulse on a new reset request.
- link_up_out  output  1  high while good words keep arriving.
- good_count_out  output  16  accepted-word counter, saturating.
- bad_count_out  output  16  rejected-word counter, saturating.

Behaviour:
- Word fields:
  - x = [43:33]
  - y = [31:21]
  - dir = [19:11]
  - game = [7:5]
  - rst = [3]
  - spare = {[32],[20],[10:8],[4],[2:0]}
- Classification, evaluated combinationally on any cycle with axiiv=1:
  - all-zero word: ignored; no counter changes.
  - good word: nonzero, x<TRACK_W, y<TRACK_H, dir<DIR_MAX, spare==0.
  - anything else: bad word.
  - axiiv=0: no action.
- Good word, registered the cycle after acceptance:
  - write x/y/dir/game into shadow registers;
  - good_count +1, saturating at 16'hFFFF;
  - reset timeout counter to 0;
  - link_up_out=1.
- Bad word: bad_count +1 (saturating); shadow registers and timeout counter unchanged.
- Publish:
  - On frame_start_in=1, copy shadow registers to the opp_*_out registers. Outputs are valid the following cycle.
  - Outputs change on no other cycle.
  - Good word and frame_start_in on the same cycle: the publish uses the pre-update shadow. The new word appears at the next frame_start.
- Reset pulse:
  - Keep prev_rst = rst bit of the last good word.
  - A good word with rst=1 while prev_rst=0 asserts opp_reset_pulse_out for exactly 1 cycle (the cycle after acceptance).
  - Repeated words with rst=1 do not re-pulse. A good word with rst=0 re-arms.
  - Bad words never affect prev_rst.
- Timeout:
  - 23-bit counter, increments every cycle when no good word arrives, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, link_up_out falls to 0 on that cycle's edge.
  - On link loss, prev_rst clears to 0. Shadow and published state are held (last known position stays on screen).
- State machine (link), 2 states:
  - LINK_DOWN: reset state. Goes to LINK_UP on a good word.
  - LINK_UP: goes to LINK_DOWN on timeout.
  - link_up_out = (state==LINK_UP).
- Reset values (async, rst_in=1):
  - opp_x_out=0, opp_y_out=0, opp_dir_out=0, opp_game_out=0;
  - shadow registers 0;
  - opp_reset_pulse_out=0, link_up_out=0, prev_rst=0;
  - both counters 0, timeout counter 0, state LINK_DOWN.
  - Reset mid-word discards the word. Deasserting reset needs no frame_start to take effect.
- Latency:
  - word to shadow: 1 cycle;
  - shadow to outputs: next frame_start + 1 cycle.

Test Plan:
- Reset asserted, then released; no input -> all outputs 0, link_up_out=0 indefinitely.
- Good word x=191, y=191, dir=270, game=1, rst=0, then frame_start -> link_up_out=1 one cycle after the word; good_count=1; outputs remain 0 until frame_start, then x=191, y=191, dir=270, game=1.
- Words with x=600, then dir=400, then spare bit 32 set, then all-zero; frame_start -> bad_count=3, good_count=0, outputs unchanged, link_up_out stays 0.
- Good words with rst=1, 1, 0, 1 -> exactly two one-cycle pulses, one after the 1st word and one after the 4th.
- TIMEOUT_CYCLES=100: one good word, then silence -> link_up_out falls exactly 100 cycles after the acceptance edge; published x/y held; the next good word restores link_up_out=1.
- Good word on the same cycle as frame_start -> outputs hold the old shadow, and the new values appear after the next frame_start; a 70000-word good burst saturates good_count at 65535.

Source files
------------

// File: rtl/opponent_state_tracker.sv
// rtl/opponent_state_tracker.sv - validates opponent words, holds and frame-publishes opponent kart state
//
// Purpose:
//   Takes 44-bit opponent words from the Ethernet receive path on eth_refclk.
//   It drops all-zero words, rejects malformed or out-of-range words, and keeps
//   the last good state in shadow registers. It copies that state to the viewer
//   outputs only on frame_start_in, so a displayed frame never mixes two packets.
//   It also tracks link liveness with a timeout, and turns the opponent's reset
//   request bit into a single-cycle pulse.
//
// Ports:
//   clk_in              eth_refclk (50 MHz)
//   rst_in              asynchronous, active-high reset
//   axiiv               word valid from the receive block
//   axiid[43:0]         opponent word: x[43:33] y[31:21] dir[19:11] game[7:5] rst[3]
//   frame_start_in      one-cycle pulse at the start of each displayed frame
//   opp_x_out[10:0]     published opponent x
//   opp_y_out[10:0]     published opponent y
//   opp_dir_out[8:0]    published opponent direction (degrees)
//   opp_game_out[2:0]   published game status
//   opp_reset_pulse_out one-cycle pulse on a new reset request
//   link_up_out         high while good words keep arriving
//   good_count_out      accepted-word counter, saturating
//   bad_count_out       rejected-word counter, saturating

module opponent_state_tracker #(
  parameter int TRACK_W        = 512,
  parameter int TRACK_H        = 512,
  parameter int DIR_MAX        = 360,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiiv,
  input  logic [43:0] axiid,
  input  logic        frame_start_in,
  output logic [10:0] opp_x_out,
  output logic [10:0] opp_y_out,
  output logic [8:0]  opp_dir_out,
  output logic [2:0]  opp_game_out,
  output logic        opp_reset_pulse_out,
  output logic        link_up_out,
  output logic [15:0] good_count_out,
  output logic [15:0] bad_count_out
);

  localparam logic [31:0] X_LIMIT     = 32'(TRACK_W);
  localparam logic [31:0] Y_LIMIT     = 32'(TRACK_H);
  localparam logic [31:0] DIR_LIMIT   = 32'(DIR_MAX);
  localparam logic [22:0] TIMEOUT_MAX = 23'(TIMEOUT_CYCLES);
  localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_t;

  link_state_t state, state_next;

  // Word field extraction
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [8:0]  w_dir;
  logic [2:0]  w_game;
  logic        w_rst;
  logic [8:0]  w_spare;

  assign w_x     = axiid[43:33];
  assign w_y     = axiid[31:21];
  assign w_dir   = axiid[19:11];
  assign w_game  = axiid[7:5];
  assign w_rst   = axiid[3];
  assign w_spare = {axiid[32], axiid[20], axiid[10:8], axiid[4], axiid[2:0]};

  // Classification
  logic word_nonzero;
  logic fields_ok;
  logic good_word;
  logic bad_word;

  assign word_nonzero = |axiid;
  assign fields_ok    = (32'(w_x) < X_LIMIT) && (32'(w_y) < Y_LIMIT) &&
                        (32'(w_dir) < DIR_LIMIT) && (w_spare == 9'd0);
  assign good_word    = axiiv && word_nonzero && fields_ok;
  assign bad_word     = axiiv && word_nonzero && !fields_ok;

  // Shadow (last good word) and bookkeeping registers
  logic [10:0] shadow_x;
  logic [10:0] shadow_y;
  logic [8:0]  shadow_dir;
  logic [2:0]  shadow_game;
  logic        prev_rst;
  logic [22:0] timeout_cnt;
  logic [22:0] timeout_cnt_next;
  logic        timeout_reached;

  // The timeout counter restarts on every good word. Otherwise it climbs and
  // parks at TIMEOUT_MAX. The link drops on the edge that lands it there.
  always_comb begin
    timeout_cnt_next = timeout_cnt;
    if (good_word) begin
      timeout_cnt_next = 23'd0;
    end else if (timeout_cnt != TIMEOUT_MAX) begin
      timeout_cnt_next = timeout_cnt + 23'd1;
    end
  end

  assign timeout_reached = !good_word && (timeout_cnt_next == TIMEOUT_MAX);

  // Link state machine: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      LINK_DOWN: if (good_word)       state_next = LINK_UP;
      LINK_UP:   if (timeout_reached) state_next = LINK_DOWN;
      default:                        state_next = LINK_DOWN;
    endcase
  end

  // Link state machine: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= LINK_DOWN;
    end else begin
      state <= state_next;
    end
  end

  assign link_up_out = (state == LINK_UP);

  // Timeout counter and reset-request edge tracking
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timeout_cnt         <= 23'd0;
      prev_rst            <= 1'b0;
      opp_reset_pulse_out <= 1'b0;
    end else begin
      timeout_cnt         <= timeout_cnt_next;
      // Pulse only on a 0->1 change of the rst bit across good words.
      opp_reset_pulse_out <= good_word && w_rst && !prev_rst;
      if (good_word) begin
        prev_rst <= w_rst;
      end else if (timeout_reached) begin
        // Re-arm after a link loss, so a reconnecting opponent's reset request is seen.
        prev_rst <= 1'b0;
      end
    end
  end

  // Shadow registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow_x    <= 11'd0;
      shadow_y    <= 11'd0;
      shadow_dir  <= 9'd0;
      shadow_game <= 3'd0;
    end else if (good_word) begin
      shadow_x    <= w_x;
      shadow_y    <= w_y;
      shadow_dir  <= w_dir;
      shadow_game <= w_game;
    end
  end

  // Publish the shadow only at frame start. A word accepted on the same edge is
  // not yet in the shadow, so it waits for the next frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      opp_x_out    <= 11'd0;
      opp_y_out    <= 11'd0;
      opp_dir_out  <= 9'd0;
      opp_game_out <= 3'd0;
    end else if (frame_start_in) begin
      opp_x_out    <= shadow_x;
      opp_y_out    <= shadow_y;
      opp_dir_out  <= shadow_dir;
      opp_game_out <= shadow_game;
    end
  end

  // Saturating word counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      good_count_out <= 16'd0;
      bad_count_out  <= 16'd0;
    end else begin
      if (good_word && (good_count_out != COUNT_MAX)) begin
        good_count_out <= good_count_out + 16'd1;
      end
      if (bad_word && (bad_count_out != COUNT_MAX)) begin
        bad_count_out <= bad_count_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_opponent_state_tracker.sv
// tb/tb_opponent_state_tracker.sv - directed self-checking bench for opponent_state_tracker

module tb_opponent_state_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        axiiv;
  logic [43:0] axiid;
  logic        frame_start_in;
  logic [10:0] opp_x_out;
  logic [10:0] opp_y_out;
  logic [8:0]  opp_dir_out;
  logic [2:0]  opp_game_out;
  logic        opp_reset_pulse_out;
  logic        link_up_out;
  logic [15:0] good_count_out;
  logic [15:0] bad_count_out;

  int errors = 0;
  int checks = 0;

  opponent_state_tracker #(
    .TRACK_W(512),
    .TRACK_H(512),
    .DIR_MAX(360),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .axiiv(axiiv),
    .axiid(axiid),
    .frame_start_in(frame_start_in),
    .opp_x_out(opp_x_out),
    .opp_y_out(opp_y_out),
    .opp_dir_out(opp_dir_out),
    .opp_game_out(opp_game_out),
    .opp_reset_pulse_out(opp_reset_pulse_out),
    .link_up_out(link_up_out),
    .good_count_out(good_count_out),
    .bad_count_out(bad_count_out)
  );

  always #10 clk_in = ~clk_in;

  function automatic logic [43:0] mk(input logic [10:0] x, input logic [10:0] y,
                                     input logic [8:0] d, input logic [2:0] g,
                                     input logic r);
    return {x, 1'b0, y, 1'b0, d, 3'b000, g, 1'b0, r, 3'b000};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [43:0] w;
    rst_in = 1'b1;
    axiiv = 1'b0;
    axiid = 44'd0;
    frame_start_in = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_x", 32'(opp_x_out), 0);
    chk("rst_y", 32'(opp_y_out), 0);
    chk("rst_dir", 32'(opp_dir_out), 0);
    chk("rst_game", 32'(opp_game_out), 0);
    chk("rst_pulse", 32'(opp_reset_pulse_out), 0);
    chk("rst_link", 32'(link_up_out), 0);
    chk("rst_good", 32'(good_count_out), 0);
    chk("rst_bad", 32'(bad_count_out), 0);

    rst_in = 1'b0;
    repeat (150) tick();
    chk("idle_link", 32'(link_up_out), 0);
    chk("idle_x", 32'(opp_x_out), 0);

    // malformed words plus an all-zero word, then a frame start
    axiiv = 1'b1;
    axiid = mk(11'd600, 11'd10, 9'd10, 3'd0, 1'b0);
    tick();
    axiid = mk(11'd10, 11'd10, 9'd400, 3'd0, 1'b0);
    tick();
    w = mk(11'd10, 11'd10, 9'd10, 3'd0, 1'b0);
    w[32] = 1'b1;
    axiid = w;
    tick();
    axiid = 44'd0;
    tick();
    axiiv = 1'b0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    chk("bad_cnt3", 32'(bad_count_out), 3);
    chk("bad_good0", 32'(good_count_out), 0);
    chk("bad_x", 32'(opp_x_out), 0);
    chk("bad_link", 32'(link_up_out), 0);

    // first good word
    axiiv = 1'b1;
    axiid = mk(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
    tick();
    axiiv = 1'b0;
    chk("good_link", 32'(link_up_out), 1);
    chk("good_cnt1", 32'(good_count_out), 1);
    chk("good_x_held", 32'(opp_x_out), 0);
    repeat (3) tick();
    chk("good_x_prefs", 32'(opp_x_out), 0);
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    chk("pub_x", 32'(opp_x_out), 191);
    chk("pub_y", 32'(opp_y_out), 191);
    chk("pub_dir", 32'(opp_dir_out), 270);
    chk("pub_game", 32'(opp_game_out), 1);

    // reset-request edge detection: rst bits 1,1,0,1
    axiiv = 1'b1;
    axiid = mk(11'd191, 11'd191, 9'd270, 3'd1, 1'b1);
    tick();
    chk("pulse_w1", 32'(opp_reset_pulse_out), 1);
    axiid = mk(11'd191, 11'd191, 9'd270, 3'd1, 1'b1);
    tick();
    chk("pulse_w2", 32'(opp_reset_pulse_out), 0);
    axiid = mk(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
    tick();
    chk("pulse_w3", 32'(opp_reset_pulse_out), 0);
    axiid = mk(11'd191, 11'd191, 9'd270, 3'd1, 1'b1);
    tick();
    chk("pulse_w4", 32'(opp_reset_pulse_out), 1);
    axiiv = 1'b0;
    chk("pulse_good5", 32'(good_count_out), 5);

    // timeout: link must drop exactly 100 edges after the last acceptance edge
    tick();
    chk("pulse_end", 32'(opp_reset_pulse_out), 0);
    repeat (98) tick();
    chk("to_link_99", 32'(link_up_out), 1);
    tick();
    chk("to_link_100", 32'(link_up_out), 0);
    chk("to_x_held", 32'(opp_x_out), 191);
    chk("to_y_held", 32'(opp_y_out), 191);

    // reconnect: link returns, and the rst request pulses again because link loss re-armed it
    axiiv = 1'b1;
    axiid = mk(11'd5, 11'd6, 9'd7, 3'd0, 1'b1);
    tick();
    axiiv = 1'b0;
    chk("re_link", 32'(link_up_out), 1);
    chk("re_pulse", 32'(opp_reset_pulse_out), 1);

    // good word on the same cycle as frame start
    axiiv = 1'b1;
    axiid = mk(11'd10, 11'd20, 9'd30, 3'd2, 1'b0);
    tick();
    axiid = mk(11'd100, 11'd200, 9'd300, 3'd5, 1'b0);
    frame_start_in = 1'b1;
    tick();
    axiiv = 1'b0;
    frame_start_in = 1'b0;
    chk("same_x", 32'(opp_x_out), 10);
    chk("same_y", 32'(opp_y_out), 20);
    chk("same_dir", 32'(opp_dir_out), 30);
    chk("same_game", 32'(opp_game_out), 2);
    tick();
    chk("same_hold_x", 32'(opp_x_out), 10);
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    chk("next_x", 32'(opp_x_out), 100);
    chk("next_y", 32'(opp_y_out), 200);
    chk("next_dir", 32'(opp_dir_out), 300);
    chk("next_game", 32'(opp_game_out), 5);

    // range boundaries: 511/511/359 accepted, y=512 and dir=360 rejected
    axiiv = 1'b1;
    axiid = mk(11'd511, 11'd511, 9'd359, 3'd7, 1'b0);
    tick();
    axiid = mk(11'd5, 11'd512, 9'd5, 3'd0, 1'b0);
    tick();
    axiid = mk(11'd0, 11'd0, 9'd360, 3'd0, 1'b0);
    tick();
    axiiv = 1'b0;
    chk("bnd_good", 32'(good_count_out), 9);
    chk("bnd_bad", 32'(bad_count_out), 5);
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    chk("bnd_x", 32'(opp_x_out), 511);
    chk("bnd_y", 32'(opp_y_out), 511);
    chk("bnd_dir", 32'(opp_dir_out), 359);
    chk("bnd_game", 32'(opp_game_out), 7);

    // saturating good counter
    axiiv = 1'b1;
    axiid = mk(11'd1, 11'd2, 9'd3, 3'd4, 1'b0);
    repeat (70000) tick();
    axiiv = 1'b0;
    chk("sat_good", 32'(good_count_out), 65535);
    chk("sat_bad", 32'(bad_count_out), 5);
    chk("sat_link", 32'(link_up_out), 1);

    // asynchronous reset between clock edges
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst_x", 32'(opp_x_out), 0);
    chk("arst_good", 32'(good_count_out), 0);
    chk("arst_link", 32'(link_up_out), 0);
    tick();
    rst_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
